inst_fetch_buf: RTL



---
 rtl/inst_fetch_buf_if.sv | 24 ++
 rtl/inst_fetch_buf.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buf_if.sv
// Fetch-stage bundle: instruction memory port, branch redirect and decoder window.
// The master modport is the fetch buffer; the slave modport is its environment.
interface inst_fetch_buf_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        brRedir;
  logic [31:0] brPc;
  logic [3:0]  idStepPc;
  logic        ifValid;
  logic [31:0] istrWord;
  logic [31:0] istrPc;

  modport master (
    output memReq, memAddr, ifValid, istrWord, istrPc,
    input  memAck, memData, brRedir, brPc, idStepPc
  );

  modport slave (
    input  memReq, memAddr, ifValid, istrWord, istrPc,
    output memAck, memData, brRedir, brPc, idStepPc
  );
endinterface

// File: rtl/inst_fetch_buf.sv
// Instruction prefetch buffer: word fetches are split into halfwords in a circular
// queue, and the decoder sees a 32-bit window at the queue head.
module inst_fetch_buf #(
  parameter int          QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  inst_fetch_buf_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] ISSUE_MAX = CW'(QDEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_pend_addr;
  logic          r_skip_lo;
  logic [31:0]   r_pc;
  logic [15:0]   r_q [QDEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [31:0]   w_br_pc;
  logic [31:0]   w_br_addr;
  logic          w_if_valid;
  logic          w_ack_ok;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [PW-1:0] w_head1;
  logic [PW-1:0] w_tail1;
  logic [31:0]   w_istr_word;

  assign w_br_pc    = bus.brPc & 32'hFFFF_FFFE;
  assign w_br_addr  = w_br_pc & 32'hFFFF_FFFC;
  assign w_if_valid = (r_count >= CW'(2));
  assign w_ack_ok   = (r_state == S_WAIT) && bus.memAck && !bus.brRedir;
  assign w_head1    = r_head + PW'(1);
  assign w_tail1    = r_tail + PW'(1);

  assign bus.memReq   = r_mem_req;
  assign bus.memAddr  = r_mem_addr;
  assign bus.ifValid  = w_if_valid;
  assign bus.istrWord = w_istr_word;
  assign bus.istrPc   = r_pc;

  // Halfwords enqueued and popped this cycle; a redirect overrides both.
  always_comb begin
    w_push = 2'd0;
    w_pop  = 2'd0;
    if (w_ack_ok) begin
      w_push = r_skip_lo ? 2'd1 : 2'd2;
    end else begin
      w_push = 2'd0;
    end
    if (w_if_valid && !bus.brRedir) begin
      case (bus.idStepPc)
        4'd2:    w_pop = 2'd1;
        4'd4:    w_pop = 2'd2;
        default: w_pop = 2'd0;
      endcase
    end else begin
      w_pop = 2'd0;
    end
  end

  // Decoder window at the queue head, forced to zero until two halfwords exist.
  always_comb begin
    w_istr_word = 32'd0;
    if (w_if_valid) begin
      w_istr_word = {r_q[w_head1], r_q[r_head]};
    end else begin
      w_istr_word = 32'd0;
    end
  end

  // Fetch FSM: one request in flight; DROP swallows the reply of a pre-redirect request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= RESET_PC & 32'hFFFF_FFFC;
      r_pend_addr <= RESET_PC & 32'hFFFF_FFFC;
      r_skip_lo   <= RESET_PC[1];
    end else begin
      if (bus.brRedir) begin
        r_skip_lo <= w_br_pc[1];
      end else if (w_ack_ok) begin
        r_skip_lo <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.brRedir) begin
            r_mem_addr <= w_br_addr;
          end else if (r_count <= ISSUE_MAX) begin
            r_mem_req <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.memAck) begin
            r_mem_req  <= 1'b0;
            r_state    <= S_IDLE;
            r_mem_addr <= bus.brRedir ? w_br_addr : (r_mem_addr + 32'd4);
          end else if (bus.brRedir) begin
            r_pend_addr <= w_br_addr;
            r_state     <= S_DROP;
          end
        end
        S_DROP: begin
          if (bus.memAck) begin
            r_mem_req  <= 1'b0;
            r_state    <= S_IDLE;
            r_mem_addr <= bus.brRedir ? w_br_addr : r_pend_addr;
          end else if (bus.brRedir) begin
            r_pend_addr <= w_br_addr;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Halfword queue storage, pointers, occupancy and decode PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_q[i] <= 16'd0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= RESET_PC;
    end else if (bus.brRedir) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= w_br_pc;
    end else begin
      if (w_ack_ok) begin
        if (r_skip_lo) begin
          r_q[r_tail] <= bus.memData[31:16];
        end else begin
          r_q[r_tail]  <= bus.memData[15:0];
          r_q[w_tail1] <= bus.memData[31:16];
        end
      end
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_pc    <= r_pc + {29'd0, w_pop, 1'b0};
    end
  end
endmodule
